// File: rtl/usb_tx_if.sv
// usb_tx_if: byte-buffer handshake, shift-register strobes and line-status signals of the USB transmit sequencer
// master: buffer/shift-register side (drives tx_start/tx_data/tx_valid/tx_last/serial_in)
// slave : usb_tx_ctrl (drives tx_ready, load/shift strobes, load_data, eop, stuff_bit, busy, tx_done, tx_error)
interface usb_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       serial_in;
  logic       load_enable;
  logic [7:0] load_data;
  logic       shift_enable;
  logic       eop;
  logic       stuff_bit;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  modport master (
    output tx_start, tx_data, tx_valid, tx_last, serial_in,
    input  tx_ready, load_enable, load_data, shift_enable, eop, stuff_bit, busy, tx_done, tx_error
  );
  modport slave (
    input  tx_start, tx_data, tx_valid, tx_last, serial_in,
    output tx_ready, load_enable, load_data, shift_enable, eop, stuff_bit, busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB transmit sequencer - SYNC, payload bytes and EOP timing for an LSB-first shift register
// Ports: clk, rst (sync, active-high), bus (usb_tx_if.slave).
// Parameters: CLKS_PER_BIT (>=2), SYNC_BYTE, EOP_BITS.
// Optional: define USB_TX_BIT_STUFF_EN to insert a stuff period after six consecutive ones on the wire.
module usb_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'h80,
  parameter int unsigned EOP_BITS     = 2
) (
  input logic       clk,
  input logic       rst,
  usb_tx_if.slave   bus
);
  localparam int unsigned EOP_CYC = EOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CW = (EOP_CYC > 2) ? $clog2(EOP_CYC) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_SYNC, SEND, EOP, IDLE_J} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic          last_q, done_q;
  logic          tick, dec, byte_end, take, under;
  logic          stuffing, stuff_now;
  // tick: last cycle of a bit (or stuff) period; dec: the shift/load decision happens now
  assign tick     = state == SEND && clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign dec      = tick && !stuff_now;
  assign byte_end = dec && bit_cnt == 3'd7;
  assign take     = byte_end && !last_q && bus.tx_valid;
  assign under    = byte_end && !last_q && !bus.tx_valid;
`ifdef USB_TX_BIT_STUFF_EN
  logic [2:0] ones;
  // a sixth one defers the decision by one bit period; stuff period ends are not wire samples
  assign stuff_now = tick && !stuffing && bus.serial_in && ones == 3'd5;
  always_ff @(posedge clk) begin
    if (rst || state == LOAD_SYNC) begin
      ones     <= 3'd0;
      stuffing <= 1'b0;
    end else if (tick) begin
      stuffing <= stuff_now;
      if (!stuffing) ones <= (stuff_now || !bus.serial_in) ? 3'd0 : ones + 3'd1;
    end
  end
`else
  logic unused_serial_in;
  assign unused_serial_in = bus.serial_in;
  assign stuffing  = 1'b0;
  assign stuff_now = 1'b0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_cnt <= 3'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clk_cnt <= (state_nx != state || tick || state == IDLE) ? '0 : clk_cnt + 1'b1;
      bit_cnt <= (state == LOAD_SYNC || take) ? 3'd0 : (dec && bit_cnt != 3'd7) ? bit_cnt + 3'd1 : bit_cnt;
      last_q  <= state == LOAD_SYNC ? 1'b0 : take ? bus.tx_last : last_q;
      done_q  <= state == IDLE_J && state_nx == IDLE;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = bus.tx_start ? LOAD_SYNC : IDLE;
      LOAD_SYNC: state_nx = SEND;
      SEND:      state_nx = (byte_end && (last_q || !bus.tx_valid)) ? EOP : SEND;
      EOP:       state_nx = clk_cnt == CW'(EOP_CYC - 1) ? IDLE_J : EOP;
      IDLE_J:    state_nx = clk_cnt == CW'(CLKS_PER_BIT - 1) ? IDLE : IDLE_J;
      default:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.busy         = state != IDLE;
    bus.eop          = state == EOP;
    bus.stuff_bit    = stuffing;
    bus.shift_enable = dec && bit_cnt != 3'd7;
    bus.load_enable  = state == LOAD_SYNC || take;
    bus.load_data    = state == LOAD_SYNC ? SYNC_BYTE : take ? bus.tx_data : 8'h00;
    bus.tx_ready     = take;
    bus.tx_error     = under;
    bus.tx_done      = done_q;
  end
endmodule

// File: doc/usb_tx_ctrl.md
Name: usb_tx_ctrl

Overview:
- Transmit sequencer for the USB encryptor's outbound path.
- Drives the 8-bit parallel-to-serial shift register (LSB-first) and emits the SYNC byte, the payload bytes and the EOP.
- Takes bytes from the upstream packet buffer via a valid/ready handshake and times each bit period.
- Its outputs feed the shift register and the NRZI/line encoder.

Parameters:
CLKS_PER_BIT, 8, clock cycles per USB bit period (>=2)
SYNC_BYTE, 8'h80, first byte loaded; serialises LSB-first as 00000001
EOP_BITS, 2, bit periods eop is held high (SE0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_start  in  1  one-cycle request to begin a packet
tx_data  in  8  payload byte from buffer
tx_valid  in  1  tx_data valid
tx_last  in  1  qualifies tx_data as final payload byte
tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle
serial_in  in  1  current serial_out of shift register (bit on wire)
load_enable  out  1  one-cycle load strobe to shift register
load_data  out  8  parallel value for shift register
shift_enable  out  1  one-cycle shift strobe to shift register
eop  out  1  high during EOP; encoder drives SE0
stuff_bit  out  1  high during inserted stuff-bit period
busy  out  1  packet in progress
tx_done  out  1  one-cycle pulse on packet completion
tx_error  out  1  one-cycle pulse on buffer underrun

Behaviour:
- Reset: every output 0, load_data 8'h00, state IDLE, all counters 0. Applies on the next edge even mid-packet; eop drops immediately. The interrupted packet is abandoned with no tx_done.
- States: IDLE, LOAD_SYNC, SEND, EOP, IDLE_J.
- IDLE:
  - busy=0.
  - tx_start=1 -> LOAD_SYNC.
  - tx_start while not IDLE is ignored.
- LOAD_SYNC (1 cycle):
  - load_enable=1, load_data=SYNC_BYTE, busy=1.
  - -> SEND with bit_cnt=0, clk_cnt=0.
- SEND:
  - clk_cnt counts 0..CLKS_PER_BIT-1; a bit ends on the cycle clk_cnt==CLKS_PER_BIT-1.
  - Bit end with bit_cnt<7: shift_enable=1, bit_cnt++.
  - Bit end with bit_cnt==7 (byte complete), checked in this order:
    - Current byte flagged last: no strobe; -> EOP.
    - Else if tx_valid=1: load_enable=1, load_data=tx_data, tx_ready=1 in the same cycle; latch tx_last; bit_cnt=0. There is no idle gap between bytes.
    - Else (underrun): tx_error=1; -> EOP.
  - SYNC is never flagged last.
  - load_enable and shift_enable are never both high.
- EOP:
  - eop=1 for EOP_BITS*CLKS_PER_BIT cycles; no strobes.
  - -> IDLE_J.
- IDLE_J:
  - eop=0 for CLKS_PER_BIT cycles (J state).
  - -> IDLE; tx_done=1 on the first IDLE cycle, busy=0 in that cycle.
- Latency: tx_start at cycle 0 -> load_enable at cycle 1 -> SYNC bit 0 on wire from cycle 2.
- tx_ready pulses only inside SEND at a byte boundary; tx_data is sampled only then.

Optional Feature:
- Macro USB_TX_BIT_STUFF_EN.
- Defined:
  - A ones counter samples serial_in at every bit end in SEND (SYNC included). serial_in=0 clears it.
  - When a sampled 1 makes the count 6, the next bit period is a stuff period: stuff_bit=1 for CLKS_PER_BIT cycles, no shift/load, bit_cnt frozen, ones counter cleared. The shift/load decision for the sampled bit happens in the cycle after the stuff period ends.
  - A stuff due after the final bit is inserted before EOP.
- Undefined: stuff_bit tied 0, no stuff periods, no ones counter.

Test Plan:
- Reset at cycle 40 of a packet -> cycle 41: busy=0, eop=0, all strobes 0. A new tx_start then behaves as from reset.
- CLKS_PER_BIT=8, one byte 8'hA5 with tx_last=1, tx_start at cycle 0:
  - load_enable at cycles 1 and 65 (tx_ready at 65, load_data=8'hA5).
  - shift_enable at 9,17,...,57 and 73,...,121.
  - eop high for cycles 130-145; tx_done at 154.
- Three bytes 11,22,33 with tx_valid held high, last on 33 -> tx_ready at 65,129,193; eop begins at 258; no gap cycles.
- Underrun: tx_valid=0 at cycle 65 after SYNC -> tx_error at 65, eop high for cycles 66-81, tx_done at 90.
- USB_TX_BIT_STUFF_EN, single byte 8'hFF last -> after data bit 4 (6th consecutive 1) stuff_bit high for 8 cycles, shift_enable delayed 8 cycles. No second stuff; eop starts 8 cycles later than in the unstuffed case.
- tx_start pulsed at cycle 30 during SEND -> no effect; sequence and tx_done timing unchanged.
